// File: rtl/aq_sigcap_pkg.sv
// Shared definitions for the signal-capture controller: state encoding and default widths.
package aq_sigcap_pkg;

    localparam int SIGCAP_DATA_W = 32;
    localparam int SIGCAP_ADDR_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_t;

    // States in which qualified samples are written into the ring.
    function automatic logic is_busy(input cap_state_t s);
        return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/aq_sigcap_trig.sv
// Level/edge trigger evaluator: holds the latched compare config and the previous sample.
module aq_sigcap_trig
    import aq_sigcap_pkg::*;
#(
    parameter int DATA_W = SIGCAP_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              sample,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [DATA_W-1:0] trig_edge,
    input  logic [DATA_W-1:0] data_in,
    output logic              hit_cond
);

    logic [DATA_W-1:0] cfg_mask;
    logic [DATA_W-1:0] cfg_value;
    logic [DATA_W-1:0] cfg_edge;
    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic              lvl;
    logic              edg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_mask   <= '0;
            cfg_value  <= '0;
            cfg_edge   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            if (load) begin
                cfg_mask  <= trig_mask;
                cfg_value <= trig_value;
                cfg_edge  <= trig_edge;
            end
            // A new run must not compare against a sample from the previous run.
            if (clear) begin
                prev_valid <= 1'b0;
            end else if (sample) begin
                prev       <= data_in;
                prev_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        lvl      = (((data_in ^ cfg_value) & cfg_mask) == '0);
        edg      = (cfg_edge == '0) ||
                   (prev_valid && (((data_in ^ prev) & cfg_edge) == cfg_edge));
        hit_cond = lvl && edg;
    end

endmodule

// File: rtl/aq_sigcap_capture.sv
// Capture controller driving port A of the sample RAM: ring-buffer writes around a
// level/edge trigger, keeping PRE_COUNT samples before and POST_COUNT samples after it.
module aq_sigcap_capture
    import aq_sigcap_pkg::*;
#(
    parameter  int DATA_W = SIGCAP_DATA_W,
    parameter  int ADDR_W = SIGCAP_ADDR_W,
    localparam int WE_W   = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic              FORCE_TRIG,
    input  logic [ADDR_W-1:0] PRE_COUNT,
    input  logic [ADDR_W-1:0] POST_COUNT,
    input  logic [DATA_W-1:0] TRIG_MASK,
    input  logic [DATA_W-1:0] TRIG_VALUE,
    input  logic [DATA_W-1:0] TRIG_EDGE,
    input  logic              SAMPLE_EN,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [WE_W-1:0]   MEM_WE,
    output logic [DATA_W-1:0] MEM_DI,
    output logic              BUSY,
    output logic              TRIGGERED,
    output logic              DONE,
    output logic              DONE_PULSE,
    output logic [ADDR_W-1:0] TRIG_ADDR,
    output logic [ADDR_W-1:0] START_ADDR,
    output cap_state_t        STATE_DBG
);

    cap_state_t        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] pre_cfg;
    logic [ADDR_W-1:0] pre_left;
    logic [ADDR_W-1:0] post_left;
    logic              start_ok;
    logic              sample_fire;
    logic              hit_cond;

    // ABORT outranks everything, including a START in the same cycle.
    assign start_ok    = START && !ABORT && ((state == ST_IDLE) || (state == ST_DONE));
    assign sample_fire = is_busy(state) && SAMPLE_EN && !ABORT;
    assign STATE_DBG   = state;

    aq_sigcap_trig #(
        .DATA_W (DATA_W)
    ) u_trig (
        .clk        (CLK),
        .rst        (RST),
        .load       (start_ok),
        .clear      (start_ok || ABORT),
        .sample     (sample_fire),
        .trig_mask  (TRIG_MASK),
        .trig_value (TRIG_VALUE),
        .trig_edge  (TRIG_EDGE),
        .data_in    (DATA_IN),
        .hit_cond   (hit_cond)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            pre_cfg    <= '0;
            pre_left   <= '0;
            post_left  <= '0;
            MEM_ADDR   <= '0;
            MEM_WE     <= '0;
            MEM_DI     <= '0;
            BUSY       <= 1'b0;
            TRIGGERED  <= 1'b0;
            DONE       <= 1'b0;
            DONE_PULSE <= 1'b0;
            TRIG_ADDR  <= '0;
            START_ADDR <= '0;
        end else begin
            MEM_WE     <= '0;
            DONE_PULSE <= 1'b0;
            if (ABORT) begin
                state      <= ST_IDLE;
                BUSY       <= 1'b0;
                TRIGGERED  <= 1'b0;
                DONE       <= 1'b0;
                TRIG_ADDR  <= '0;
                START_ADDR <= '0;
            end else if (start_ok) begin
                pre_cfg    <= PRE_COUNT;
                pre_left   <= PRE_COUNT;
                post_left  <= POST_COUNT;
                wr_ptr     <= '0;
                BUSY       <= 1'b1;
                TRIGGERED  <= 1'b0;
                DONE       <= 1'b0;
                TRIG_ADDR  <= '0;
                START_ADDR <= '0;
                state      <= (PRE_COUNT == '0) ? ST_ARMED : ST_PRE;
            end else if (sample_fire) begin
                MEM_WE   <= '1;
                MEM_ADDR <= wr_ptr;
                MEM_DI   <= DATA_IN;
                wr_ptr   <= wr_ptr + 1'b1;
                case (state)
                    ST_PRE: begin
                        pre_left <= pre_left - 1'b1;
                        if (pre_left == 1) begin
                            state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (FORCE_TRIG || hit_cond) begin
                            TRIGGERED  <= 1'b1;
                            TRIG_ADDR  <= wr_ptr;
                            START_ADDR <= wr_ptr - pre_cfg;
                            // With no post samples the trigger sample closes the run.
                            if (post_left == '0) begin
                                state      <= ST_DONE;
                                BUSY       <= 1'b0;
                                DONE       <= 1'b1;
                                DONE_PULSE <= 1'b1;
                            end else begin
                                state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        post_left <= post_left - 1'b1;
                        if (post_left == 1) begin
                            state      <= ST_DONE;
                            BUSY       <= 1'b0;
                            DONE       <= 1'b1;
                            DONE_PULSE <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aq_sigcap_capture.sv
// Directed and randomized bench for aq_sigcap_capture with a sample-count reference model.
module tb_aq_sigcap_capture;
    import aq_sigcap_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int WE_W   = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              force_trig = 1'b0;
    logic [ADDR_W-1:0] pre_count = '0;
    logic [ADDR_W-1:0] post_count = '0;
    logic [DATA_W-1:0] trig_mask = '0;
    logic [DATA_W-1:0] trig_value = '0;
    logic [DATA_W-1:0] trig_edge = '0;
    logic              sample_en = 1'b0;
    logic [DATA_W-1:0] data_in = '0;

    logic [ADDR_W-1:0] mem_addr;
    logic [WE_W-1:0]   mem_we;
    logic [DATA_W-1:0] mem_di;
    logic              busy;
    logic              triggered;
    logic              done;
    logic              done_pulse;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] start_addr;
    cap_state_t        state_dbg;

    aq_sigcap_capture #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .START      (start),
        .ABORT      (abort),
        .FORCE_TRIG (force_trig),
        .PRE_COUNT  (pre_count),
        .POST_COUNT (post_count),
        .TRIG_MASK  (trig_mask),
        .TRIG_VALUE (trig_value),
        .TRIG_EDGE  (trig_edge),
        .SAMPLE_EN  (sample_en),
        .DATA_IN    (data_in),
        .MEM_ADDR   (mem_addr),
        .MEM_WE     (mem_we),
        .MEM_DI     (mem_di),
        .BUSY       (busy),
        .TRIGGERED  (triggered),
        .DONE       (done),
        .DONE_PULSE (done_pulse),
        .TRIG_ADDR  (trig_addr),
        .START_ADDR (start_addr),
        .STATE_DBG  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Counters and scoreboard
    int n_vec = 0;
    int n_err = 0;
    int wr_count = 0;
    int pulse_addr = -1;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    // Reference model: run described by sample counts, not by controller states
    bit                m_run;
    int                m_nsamp;
    int                m_npost;
    int                m_pre;
    int                m_post;
    logic [DATA_W-1:0] m_mask, m_value, m_edge, m_prev;
    bit                m_prev_ok;
    bit                e_we, e_busy, e_trig, e_done, e_pulse;
    int                e_taddr, e_saddr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic close_run();
        m_run   = 1'b0;
        e_done  = 1'b1;
        e_pulse = 1'b1;
    endtask

    task automatic model_step();
        int  slot;
        bit  lvl, edg, was_trig;
        e_we    = 1'b0;
        e_pulse = 1'b0;
        if (rst) begin
            m_run = 1'b0; e_done = 1'b0; e_trig = 1'b0;
            e_taddr = 0; e_saddr = 0; m_prev_ok = 1'b0;
        end else if (abort) begin
            m_run = 1'b0; e_done = 1'b0; e_trig = 1'b0;
            e_taddr = 0; e_saddr = 0; m_prev_ok = 1'b0;
        end else if (start && !m_run) begin
            m_pre = int'(pre_count); m_post = int'(post_count);
            m_mask = trig_mask; m_value = trig_value; m_edge = trig_edge;
            m_run = 1'b1; e_done = 1'b0; e_trig = 1'b0;
            e_taddr = 0; e_saddr = 0;
            m_nsamp = 0; m_npost = 0; m_prev_ok = 1'b0;
        end else if (m_run && sample_en) begin
            slot = m_nsamp % DEPTH;
            e_we = 1'b1;
            exp_q.push_back({ADDR_W'(slot), data_in});
            was_trig = e_trig;
            if (was_trig) begin
                m_npost++;
                if (m_npost == m_post) close_run();
            end else if (m_nsamp >= m_pre) begin
                lvl = (((data_in ^ m_value) & m_mask) == 0);
                edg = (m_edge == 0) || (m_prev_ok && (((data_in ^ m_prev) & m_edge) == m_edge));
                if (force_trig || (lvl && edg)) begin
                    e_trig  = 1'b1;
                    e_taddr = slot;
                    e_saddr = (slot + DEPTH - (m_pre % DEPTH)) % DEPTH;
                    if (m_post == 0) close_run();
                end
            end
            m_prev    = data_in;
            m_prev_ok = 1'b1;
            m_nsamp++;
        end
        e_busy = m_run;
    endtask

    // One clock: DUT and model advance on the same edge, outputs checked 1 time unit later.
    task automatic cyc();
        logic [ADDR_W+DATA_W-1:0] item;
        @(posedge clk);
        model_step();
        #1;
        check("mem_we", mem_we, e_we ? {WE_W{1'b1}} : {WE_W{1'b0}});
        check("busy", busy, e_busy);
        check("triggered", triggered, e_trig);
        check("done", done, e_done);
        check("done_pulse", done_pulse, e_pulse);
        check("trig_addr", trig_addr, e_taddr);
        check("start_addr", start_addr, e_saddr);
        check("state_idle", state_dbg == ST_IDLE, !e_busy && !e_done);
        if (mem_we != '0) begin
            wr_count++;
            check("wr_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                item = exp_q.pop_front();
                check("wr_addr", mem_addr, item[DATA_W +: ADDR_W]);
                check("wr_data", mem_di, item[DATA_W-1:0]);
            end
            if (done_pulse) pulse_addr = int'(mem_addr);
        end
    endtask

    // Driver tasks
    task automatic do_start(input int pre, input int post, input logic [DATA_W-1:0] mask,
                            input logic [DATA_W-1:0] value, input logic [DATA_W-1:0] edg);
        pre_count  = ADDR_W'(pre);
        post_count = ADDR_W'(post);
        trig_mask  = mask;
        trig_value = value;
        trig_edge  = edg;
        sample_en  = 1'b0;
        start      = 1'b1;
        cyc();
        start      = 1'b0;
        wr_count   = 0;
        pulse_addr = -1;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    task automatic samp(input logic en, input logic [DATA_W-1:0] d);
        sample_en = en;
        data_in   = d;
        cyc();
    endtask

    function automatic logic [DATA_W-1:0] rand_not(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        r = $urandom();
        if (r == v) r = ~r;
        return r;
    endfunction

    initial begin
        logic [DATA_W-1:0] r;
        int s;

        // Reset
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_di", mem_di, 0);
        cyc();

        // Ramp: PRE=4 POST=3, trigger on 0x10
        do_start(4, 3, 32'hFF, 32'h10, 0);
        for (int i = 0; i < 30; i++) samp(1'b1, i);
        check("ramp_writes", wr_count, 20);
        check("ramp_trig_addr", trig_addr, 16);
        check("ramp_start_addr", start_addr, 12);
        check("ramp_pulse_addr", pulse_addr, 19);
        check("ramp_done", done, 1);

        // PRE=0 POST=0 MASK=0, with a sampling gap first
        do_start(0, 0, 0, $urandom(), 0);
        samp(1'b0, $urandom());
        samp(1'b0, $urandom());
        samp(1'b1, $urandom());
        samp(1'b1, $urandom());
        samp(1'b0, 0);
        check("zero_writes", wr_count, 1);
        check("zero_trig_addr", trig_addr, 0);
        check("zero_start_addr", start_addr, 0);
        check("zero_done", done, 1);

        // Ring wrap: PRE=1020, trigger sample index 2000, random gaps
        do_start(1020, 2, '1, 32'hA5A5_0000, 0);
        s = 0;
        for (int c = 0; c < 4000 && s < 2003; c++) begin
            sample_en = ($urandom_range(0, 3) != 0);
            data_in   = (s == 2000) ? 32'hA5A5_0000 : rand_not(32'hA5A5_0000);
            if (sample_en) s++;
            cyc();
        end
        samp(1'b0, 0);
        check("wrap_trig_addr", trig_addr, 976);
        check("wrap_start_addr", start_addr, 980);
        check("wrap_done", done, 1);

        // Edge trigger on bit0; FORCE_TRIG during PRE must be ignored
        do_start(3, 2, 1, 1, 1);
        force_trig = 1'b1;
        for (int i = 0; i < 3; i++) begin r = $urandom(); samp(1'b1, r | 1); end
        force_trig = 1'b0;
        for (int i = 0; i < 4; i++) begin r = $urandom(); samp(1'b1, r | 1); end
        check("edge_hold_no_trig", triggered, 0);
        r = $urandom(); samp(1'b1, r & ~32'h1);
        r = $urandom(); samp(1'b1, r | 1);
        check("edge_trig", triggered, 1);
        for (int i = 0; i < 3; i++) samp(1'b1, $urandom());
        check("edge_trig_addr", trig_addr, 8);
        check("edge_start_addr", start_addr, 5);

        // ABORT mid-POST, then START+ABORT together, then a clean restart
        do_start(2, 10, 0, 0, 0);
        for (int i = 0; i < 6; i++) samp(1'b1, $urandom());
        check("abort_in_post", triggered, 1);
        sample_en = 1'b1;
        do_abort();
        for (int i = 0; i < 4; i++) samp(1'b1, $urandom());
        check("abort_busy", busy, 0);
        check("abort_trig", triggered, 0);
        start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) samp(1'b1, $urandom());
        check("start_abort_busy", busy, 0);
        do_start(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) samp(1'b1, $urandom());
        check("restart_writes", wr_count, 3);
        check("restart_trig_addr", trig_addr, 1);

        // Reset asserted while ARMED
        do_start(2, 5, '1, 32'hDEAD_BEEF, 0);
        for (int i = 0; i < 10; i++) samp($urandom_range(0, 1), rand_not(32'hDEAD_BEEF));
        rst = 1'b1;
        sample_en = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_run_mem_addr", mem_addr, 0);
        check("rst_run_mem_di", mem_di, 0);
        samp(1'b0, 0);

        // Randomized runs
        for (int run = 0; run < 8; run++) begin
            do_start($urandom_range(0, 20), $urandom_range(0, 20),
                     32'h1 << $urandom_range(0, 3), $urandom(),
                     ($urandom_range(0, 1) != 0) ? (32'h1 << $urandom_range(0, 3)) : 32'h0);
            for (int c = 0; c < 400 && !done; c++) begin
                force_trig = ($urandom_range(0, 49) == 0);
                samp($urandom_range(0, 9) < 7, $urandom());
            end
            force_trig = 1'b0;
            sample_en  = 1'b0;
            if (!done) do_abort();
            samp(1'b0, 0);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
